// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch->decode bundle type.
//   XLEN        - datapath width
//   INSTR_NOP   - canonical NOP (addi x0,x0,0) shown when no valid instruction
//   PC_STEP_DEF - default byte increment between sequential fetches
//   if_bundle_t - {valid, pc, instr} as presented to decode
package fetch_pkg;

  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0013;
  localparam int              PC_STEP_DEF = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_bundle_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus between the fetch stage, the instruction ROM and decode.
//   stall/redirect_*        - control from downstream
//   rom_address/rom_data    - synchronous ROM port (1-cycle read latency)
//   if_valid/if_pc/if_instr - fetched instruction presented to decode
// master = fetch stage side, slave = ROM/decode side.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] rom_address;
  logic [XLEN-1:0] rom_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    input  stall, redirect_valid, redirect_pc, rom_data,
    output rom_address, if_valid, if_pc, if_instr
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, rom_data,
    input  rom_address, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry capture/replay register with bypass mux.
//   clk_i, reset_i - clock, synchronous active-high reset
//   flush_i        - drop any held entry (redirect)
//   stall_i        - downstream not accepting; capture current word if empty
//   resp_i         - live response {valid, pc, raw rom_data}
//   out_o          - bundle to decode (held entry wins over live response)
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       stall_i,
  input  if_bundle_t resp_i,
  output if_bundle_t out_o
);

  if_bundle_t hold_q, hold_d;

  // Capture only on the first stalled edge; later stalled edges keep the
  // original entry so the outputs stay bit-identical for the whole stall.
  always_comb begin
    hold_d = hold_q;
    if (flush_i) begin
      hold_d.valid = 1'b0;
    end else if (stall_i) begin
      if (!hold_q.valid) hold_d = resp_i;
    end else begin
      hold_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    if (hold_q.valid) begin
      out_o = hold_q;
    end else begin
      out_o.valid = resp_i.valid;
      out_o.pc    = resp_i.pc;
      out_o.instr = resp_i.valid ? resp_i.instr : INSTR_NOP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction ROM address and pairs each
// returned ROM word with the PC that produced it.
//   clk   - clock, all state updates on posedge
//   reset - synchronous, active-high
//   bus   - fetch_stage_if.master (stall/redirect in, ROM port, if_* out)
// Edge priority: reset > redirect > stall > normal advance.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = PC_STEP_DEF
)(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d;
  if_bundle_t      resp, ifb;

  // resp_* describes the word arriving on rom_data this cycle, i.e. the
  // address that was on rom_address at the previous edge.
  always_comb begin
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    if (bus.redirect_valid) begin
      pc_d         = bus.redirect_pc & ~XLEN'(3);
      resp_valid_d = 1'b0;
    end else if (bus.stall) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      pc_d         = pc_q + XLEN'(PC_STEP);  // wraps mod 2^32
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp.valid = resp_valid_q;
  assign resp.pc    = resp_pc_q;
  assign resp.instr = bus.rom_data;

  fetch_hold_buffer u_hold (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (bus.redirect_valid),
    .stall_i (bus.stall),
    .resp_i  (resp),
    .out_o   (ifb)
  );

  // Registered only: no path from stall/redirect to the ROM address.
  assign bus.rom_address = pc_q;
  assign bus.if_valid    = ifb.valid;
  assign bus.if_pc       = ifb.pc;
  assign bus.if_instr    = ifb.instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_stage_if bus_if ();

  fetch_stage #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // ROM model: word i = A000_0000 + i, index = address[9:2], 1-cycle latency.
  always_ff @(posedge clk)
    bus_if.rom_data <= 32'hA000_0000 + {24'h0, bus_if.rom_address[9:2]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'h0, bus_if.if_valid}, 32'h1);
    chk({tag, ".pc"},    bus_if.if_pc, pc);
    chk({tag, ".instr"}, bus_if.if_instr, instr);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'h0, bus_if.if_valid}, 32'h0);
    chk({tag, ".instr"}, bus_if.if_instr, INSTR_NOP);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc = '0;
    step(); step();
    reset = 1'b0;
    // reset state (cycle 1 after reset)
    chk_bubble("rst");
    chk("rst.pc",   bus_if.if_pc, 32'h0);
    chk("rst.addr", bus_if.rom_address, 32'h0);

    step(); chk_out("run0", 32'h0, 32'hA000_0000);
    step(); chk_out("run1", 32'h4, 32'hA000_0001);
    step(); chk_out("run2", 32'h8, 32'hA000_0002);

    // stall 3 cycles while presenting (8, A2)
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall", 32'h8, 32'hA000_0002);
    end
    bus_if.stall = 1'b0;   // this cycle delivers the held word once
    step(); chk_out("rel0", 32'hC,  32'hA000_0003);
    step(); chk_out("rel1", 32'h10, 32'hA000_0004);

    // redirect to 0x43 while presenting pc 0x10
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0000_0043;
    step();
    bus_if.redirect_valid = 1'b0;
    chk_bubble("redir.bub");
    chk("redir.addr", bus_if.rom_address, 32'h40);
    step(); chk_out("redir0", 32'h40, 32'hA000_0010);
    step(); chk_out("redir1", 32'h44, 32'hA000_0011);

    // stall with hold occupied, then redirect+stall together
    bus_if.stall = 1'b1;
    step(); chk_out("hstall0", 32'h44, 32'hA000_0011);
    step(); chk_out("hstall1", 32'h44, 32'hA000_0011);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0000_0080;
    step();
    bus_if.redirect_valid = 1'b0;
    bus_if.stall = 1'b0;
    chk_bubble("rs.bub");
    step(); chk_out("rs0", 32'h80, 32'hA000_0020);
    step(); chk_out("rs1", 32'h84, 32'hA000_0021);

    // reset mid-stall with hold occupied
    bus_if.stall = 1'b1;
    step(); chk_out("rstall", 32'h84, 32'hA000_0021);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.stall = 1'b0;
    chk_bubble("mrst.bub");
    chk("mrst.addr", bus_if.rom_address, 32'h0);
    chk("mrst.pc",   bus_if.if_pc, 32'h0);
    step(); chk_out("mrst0", 32'h0, 32'hA000_0000);
    step(); chk_out("mrst1", 32'h4, 32'hA000_0001);

    // redirect to top of address space; low bits must be dropped, pc wraps
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus_if.redirect_valid = 1'b0;
    chk_bubble("wrap.bub");
    chk("wrap.addr", bus_if.rom_address, 32'hFFFF_FFFC);
    step(); chk_out("wrap0", 32'hFFFF_FFFC, 32'hA000_00FF);
    chk("wrap.addr2", bus_if.rom_address, 32'h0);
    step(); chk_out("wrap1", 32'h0, 32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
